bram_read_seq: RTL and testbench

- Parametrised BRAM read-address sequencer; next generation of the counter/FSM read accessor.
- Issues a programmable burst of reads from base_addr_i, stepping by stride_i.
- Honours consumer back-pressure via ready_i.
- Aligns valid_o with configurable BRAM read latency; done_o fires only after the last read beat emerges.
- Sits between the control block (start/length) and a single-port BRAM read port.

---
 rtl/bram_rd_pkg.sv | 19 +
 rtl/bram_rd_lat_pipe.sv | 44 ++++
 rtl/bram_read_seq.sv | 108 ++++++++++
 tb/tb_bram_read_seq.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_rd_pkg.sv
// rtl/bram_rd_pkg.sv - state encoding and read-latency limit shared by the BRAM read sequencer
package bram_rd_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Deepest BRAM read latency the valid delay line supports
  localparam int RD_LAT_MAX = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_RUN   = S_RUN,
    ST_DRAIN = S_DRAIN,
    ST_DONE  = S_DONE
  } rd_state_t;

endpackage

// File: rtl/bram_rd_lat_pipe.sv
// rtl/bram_rd_lat_pipe.sv - RD_LAT-deep delay line turning read enables into data-valid strobes
module bram_rd_lat_pipe
  import bram_rd_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en_i,
  output logic valid_o,
  // High when no beat remains in flight behind the one currently on valid_o,
  // so once en_i stays low the pipe is empty after this cycle.
  output logic empty_o
);

  generate
    if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
      $error("bram_rd_lat_pipe: RD_LAT outside 1..RD_LAT_MAX");
    end
  endgenerate

  logic [RD_LAT-1:0] sr;

  generate
    if (RD_LAT == 1) begin : g_one
      // Single stage: the enable is seen as valid on the next cycle
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sr <= '0;
        else          sr <= en_i;
      end
      assign empty_o = 1'b1;
    end else begin : g_multi
      // Shift issued enables toward the output stage, one stage per cycle
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sr <= '0;
        else          sr <= {sr[RD_LAT-2:0], en_i};
      end
      assign empty_o = ~|sr[RD_LAT-2:0];
    end
  endgenerate

  assign valid_o = sr[RD_LAT-1];

endmodule

// File: rtl/bram_read_seq.sv
// rtl/bram_read_seq.sv - BRAM read-address burst sequencer; define BRAM_READ_SEQ_ABORT_EN for abort_i/aborted_o
module bram_read_seq
  import bram_rd_pkg::*;
#(
  parameter int AWIDTH   = 8,
  parameter int CNT_BIT  = 31,
  parameter int STRIDE_W = 4,
  parameter int RD_LAT   = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start_i,
  input  logic [AWIDTH-1:0]   base_addr_i,
  input  logic [CNT_BIT-1:0]  cnt_val_i,
  input  logic [STRIDE_W-1:0] stride_i,
  input  logic                ready_i,
`ifdef BRAM_READ_SEQ_ABORT_EN
  input  logic                abort_i,
  output logic                aborted_o,
`endif
  output logic [AWIDTH-1:0]   addr_o,
  output logic                en_o,
  output logic                valid_o,
  output logic [CNT_BIT-1:0]  cnt_o,
  output logic                read_idle_o,
  output logic                read_run_o,
  output logic                read_done_o
);

  rd_state_t           state;
  logic [CNT_BIT-1:0]  len_q;
  logic [STRIDE_W-1:0] stride_q;
  logic                abort_req;
  logic                last_issue;
  logic                pipe_empty;

`ifdef BRAM_READ_SEQ_ABORT_EN
  logic aborted_q;

  assign abort_req = (state == ST_RUN) && abort_i;
  assign aborted_o = aborted_q && (state == ST_DONE);

  // Remember that the current burst was cut short; cleared by the next accepted start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          aborted_q <= 1'b0;
    else if (state == ST_IDLE && start_i)  aborted_q <= 1'b0;
    else if (abort_req)                    aborted_q <= 1'b1;
  end
`else
  assign abort_req = 1'b0;
`endif

  // A read is issued whenever the consumer can take it while running
  assign en_o       = (state == ST_RUN) && ready_i && !abort_req;
  assign last_issue = en_o && ((cnt_o + CNT_BIT'(1)) == len_q);

  assign read_idle_o = (state == ST_IDLE);
  assign read_run_o  = (state == ST_RUN) || (state == ST_DRAIN);
  assign read_done_o = (state == ST_DONE);

  // Burst FSM with address generation and issue counting
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      addr_o   <= '0;
      cnt_o    <= '0;
      len_q    <= '0;
      stride_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            addr_o   <= base_addr_i;
            cnt_o    <= '0;
            len_q    <= cnt_val_i;
            stride_q <= stride_i;
            state    <= (cnt_val_i == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (en_o) begin
            addr_o <= addr_o + AWIDTH'(stride_q);
            cnt_o  <= cnt_o + CNT_BIT'(1);
          end
          if (last_issue || abort_req) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (pipe_empty) state <= ST_DONE;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  bram_rd_lat_pipe #(
    .RD_LAT (RD_LAT)
  ) u_lat_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (en_o),
    .valid_o (valid_o),
    .empty_o (pipe_empty)
  );

endmodule

// File: tb/tb_bram_read_seq.sv
// tb/tb_bram_read_seq.sv - scoreboard bench for bram_read_seq at read latencies 1 and 3
module tb_bram_read_seq;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [7:0]  base_addr;
  logic [30:0] cnt_val;
  logic [3:0]  stride_v;
  logic        ready;
`ifdef BRAM_READ_SEQ_ABORT_EN
  logic        abort;
  logic        aborted_w [2];
`endif

  logic [7:0]  addr_w  [2];
  logic        en_w    [2];
  logic        valid_w [2];
  logic [30:0] cnt_w   [2];
  logic        idle_w  [2];
  logic        run_w   [2];
  logic        done_w  [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int nen    [2];
  int ndone  [2];
  int last_v [2];
  bit prev_done [2];
  int exp_n     = 0;
  bit exp_abort = 0;

  logic [7:0] aq0 [$];
  logic [7:0] aq1 [$];
  int         vq0 [$];
  int         vq1 [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bram_read_seq #(.AWIDTH(8), .CNT_BIT(31), .STRIDE_W(4), .RD_LAT(1)) u_lat1 (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_i     (start),
    .base_addr_i (base_addr),
    .cnt_val_i   (cnt_val),
    .stride_i    (stride_v),
    .ready_i     (ready),
`ifdef BRAM_READ_SEQ_ABORT_EN
    .abort_i     (abort),
    .aborted_o   (aborted_w[0]),
`endif
    .addr_o      (addr_w[0]),
    .en_o        (en_w[0]),
    .valid_o     (valid_w[0]),
    .cnt_o       (cnt_w[0]),
    .read_idle_o (idle_w[0]),
    .read_run_o  (run_w[0]),
    .read_done_o (done_w[0])
  );

  bram_read_seq #(.AWIDTH(8), .CNT_BIT(31), .STRIDE_W(4), .RD_LAT(3)) u_lat3 (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_i     (start),
    .base_addr_i (base_addr),
    .cnt_val_i   (cnt_val),
    .stride_i    (stride_v),
    .ready_i     (ready),
`ifdef BRAM_READ_SEQ_ABORT_EN
    .abort_i     (abort),
    .aborted_o   (aborted_w[1]),
`endif
    .addr_o      (addr_w[1]),
    .en_o        (en_w[1]),
    .valid_o     (valid_w[1]),
    .cnt_o       (cnt_w[1]),
    .read_idle_o (idle_w[1]),
    .read_run_o  (run_w[1]),
    .read_done_o (done_w[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_burst(input logic [7:0] base, input int n, input logic [3:0] stride);
    logic [7:0] a;
    a = base;
    exp_n = n;
    exp_abort = 1'b0;
    for (int i = 0; i < n; i++) begin
      aq0.push_back(a);
      aq1.push_back(a);
      a = a + 8'(stride);
    end
    base_addr = base;
    cnt_val   = 31'(n);
    stride_v  = stride;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0, input int d1);
    for (int g = 0; g < 400 && !(ndone[0] > d0 && ndone[1] > d1); g++) tick();
    chk(tag, 32'(ndone[0] > d0 && ndone[1] > d1), 32'd1);
    tick();
    @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("idle_after_done", 32'(idle_w[k]), 32'd1);
      chk("cnt_hold", 32'(cnt_w[k]), 32'(exp_n));
    end
    tick();
  endtask

  task automatic check_reset_values();
    for (int k = 0; k < 2; k++) begin
      chk("rst_addr",  32'(addr_w[k]),  32'd0);
      chk("rst_cnt",   32'(cnt_w[k]),   32'd0);
      chk("rst_en",    32'(en_w[k]),    32'd0);
      chk("rst_valid", 32'(valid_w[k]), 32'd0);
      chk("rst_idle",  32'(idle_w[k]),  32'd1);
      chk("rst_run",   32'(run_w[k]),   32'd0);
      chk("rst_done",  32'(done_w[k]),  32'd0);
`ifdef BRAM_READ_SEQ_ABORT_EN
      chk("rst_aborted", 32'(aborted_w[k]), 32'd0);
`endif
    end
  endtask

  // Monitor: pops expected addresses on each issue, expected valid times on each beat
  initial begin
    bit         have;
    logic [7:0] ea;
    int         et;
    int         lat;
    for (int k = 0; k < 2; k++) begin
      nen[k] = 0; ndone[k] = 0; last_v[k] = 0; prev_done[k] = 1'b0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      for (int k = 0; k < 2; k++) begin
        lat = (k == 0) ? 1 : 3;
        chk("flags_onehot", 32'(idle_w[k]) + 32'(run_w[k]) + 32'(done_w[k]), 32'd1);
        if (prev_done[k]) begin
          chk("done_one_cycle", 32'(done_w[k]), 32'd0);
          chk("idle_after_done_cycle", 32'(idle_w[k]), 32'd1);
        end
        if (en_w[k]) begin
          nen[k]++;
          have = (k == 0) ? (aq0.size() != 0) : (aq1.size() != 0);
          chk("en_expected", 32'(have), 32'd1);
          if (have) begin
            ea = (k == 0) ? aq0.pop_front() : aq1.pop_front();
            chk("en_addr", 32'(addr_w[k]), 32'(ea));
          end
          if (k == 0) vq0.push_back(cyc + lat);
          else        vq1.push_back(cyc + lat);
        end
        if (valid_w[k]) begin
          have = (k == 0) ? (vq0.size() != 0) : (vq1.size() != 0);
          chk("valid_expected", 32'(have), 32'd1);
          if (have) begin
            et = (k == 0) ? vq0.pop_front() : vq1.pop_front();
            chk("valid_latency", 32'(cyc), 32'(et));
          end
          last_v[k] = cyc;
        end
        if (done_w[k]) begin
          chk("done_all_issued", (k == 0) ? 32'(aq0.size()) : 32'(aq1.size()), 32'd0);
          chk("done_all_valid",  (k == 0) ? 32'(vq0.size()) : 32'(vq1.size()), 32'd0);
          chk("done_cnt", 32'(cnt_w[k]), 32'(exp_n));
          if (exp_n > 0) chk("done_after_last_valid", 32'(cyc), 32'(last_v[k] + 1));
          ndone[k]++;
        end
`ifdef BRAM_READ_SEQ_ABORT_EN
        chk("aborted_o", 32'(aborted_w[k]), 32'(done_w[k] & exp_abort));
`endif
        prev_done[k] = done_w[k];
      end
    end
  end

  // Directed stimulus
  initial begin
    int d0, d1, e0;
    reset_n   = 1'b0;
    start     = 1'b0;
    base_addr = 8'h00;
    cnt_val   = 31'd0;
    stride_v  = 4'd0;
    ready     = 1'b1;
`ifdef BRAM_READ_SEQ_ABORT_EN
    abort     = 1'b0;
`endif
    tick(); tick(); tick();
    @(negedge clk);
    #1;
    check_reset_values();
    tick();
    reset_n = 1'b1;
    tick();

    // Basic burst
    d0 = ndone[0]; d1 = ndone[1];
    start_burst(8'h10, 4, 4'd1);
    wait_done("burst_basic", d0, d1);

    // Address wrap
    d0 = ndone[0]; d1 = ndone[1];
    start_burst(8'hFE, 4, 4'd1);
    wait_done("burst_wrap", d0, d1);

    // Back-pressure: ready 1,0,0,1,1
    d0 = ndone[0]; d1 = ndone[1];
    start_burst(8'h40, 3, 4'd2);
    tick();
    ready = 1'b0;
    @(negedge clk);
    #1;
    chk("hold_en",   32'(en_w[0]),   32'd0);
    chk("hold_addr", 32'(addr_w[0]), 32'h42);
    tick();
    @(negedge clk);
    #1;
    chk("hold_addr2", 32'(addr_w[1]), 32'h42);
    chk("hold_cnt",   32'(cnt_w[1]),  32'd1);
    tick();
    ready = 1'b1;
    wait_done("burst_ready", d0, d1);

    // Zero stride repeats the base address
    d0 = ndone[0]; d1 = ndone[1];
    start_burst(8'h33, 2, 4'd0);
    wait_done("burst_stride0", d0, d1);

    // Zero-length burst goes straight to DONE
    d0 = ndone[0]; d1 = ndone[1];
    start_burst(8'h55, 0, 4'd1);
    @(negedge clk);
    #1;
    chk("zero_len_done", 32'(done_w[0]), 32'd1);
    chk("zero_len_run",  32'(run_w[0]),  32'd0);
    chk("zero_len_en",   32'(en_w[1]),   32'd0);
    wait_done("burst_zero", d0, d1);

    // Reset in the middle of a burst
    d0 = ndone[0]; d1 = ndone[1];
    e0 = nen[0];
    start_burst(8'h80, 8, 4'd1);
    for (int g = 0; g < 50 && nen[0] < e0 + 3; g++) begin
      @(negedge clk);
      #1;
    end
    chk("mid_reset_reach3", 32'(nen[0] - e0), 32'd3);
    tick();
    reset_n = 1'b0;
    aq0.delete(); aq1.delete(); vq0.delete(); vq1.delete();
    @(negedge clk);
    #1;
    check_reset_values();
    tick(); tick();
    reset_n = 1'b1;
    tick(); tick(); tick(); tick();
    chk("no_done_lat1", 32'(ndone[0]), 32'(d0));
    chk("no_done_lat3", 32'(ndone[1]), 32'(d1));
    start_burst(8'h80, 8, 4'd3);
    wait_done("burst_after_reset", d0, d1);

`ifdef BRAM_READ_SEQ_ABORT_EN
    // Abort after two issues
    d0 = ndone[0]; d1 = ndone[1];
    e0 = nen[0];
    start_burst(8'h20, 10, 4'd1);
    for (int g = 0; g < 50 && nen[0] < e0 + 2; g++) begin
      @(negedge clk);
      #1;
    end
    chk("abort_reach2", 32'(nen[0] - e0), 32'd2);
    tick();
    abort = 1'b1;
    aq0.delete(); aq1.delete();
    exp_n = 2;
    exp_abort = 1'b1;
    @(negedge clk);
    #1;
    chk("abort_en", 32'(en_w[0]), 32'd0);
    tick();
    abort = 1'b0;
    wait_done("burst_abort", d0, d1);
`endif

    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
